// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input sync, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, single-word holding register with valid/ready.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam bit PAR_ODD = (PARITY_ODD != 0);
  localparam bit PAR_EN  = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 rx_meta, rxs, rxs_d;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_r, frm_acc;

  logic maj, at_mid, at_wrap, start_det, last_data, last_stop, complete;

  assign maj       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign at_mid    = (cnt == CW'(M + 1));
  assign at_wrap   = (cnt == CW'(OVERSAMPLE - 1));
  assign start_det = rxs_d & ~rxs;
  assign last_data = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop = (bit_idx == BW'(STOP_BITS - 1));
  assign complete  = (state == STOP) && at_mid && last_stop;
  assign busy      = (state != IDLE);

  // Sync flops reset high so a line idling high never looks like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_det) state_nxt = START;
      START:  if (at_mid && maj) state_nxt = IDLE;
              else if (at_wrap)  state_nxt = DATA;
      DATA:   if (at_wrap && last_data) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY: if (at_wrap) state_nxt = STOP;
      STOP:   if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit index restarts on every state change so DATA and STOP each count from 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (state == IDLE || state_nxt == IDLE || at_wrap) cnt <= '0;
      else                                              cnt <= cnt + 1'b1;
      if (state_nxt != state) bit_idx <= '0;
      else if (at_wrap)       bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shift_reg <= '0;
      par_err_r <= 1'b0;
      frm_acc   <= 1'b0;
    end else begin
      if (cnt == CW'(M - 1)) samp_a <= rxs;
      if (cnt == CW'(M))     samp_b <= rxs;
      if (state == IDLE && start_det) begin
        par_err_r <= 1'b0;
        frm_acc   <= 1'b0;
      end
      if (state == DATA && at_mid)   shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
      if (state == PARITY && at_mid) par_err_r <= ((^shift_reg) ^ maj) != PAR_ODD;
      if (state == STOP && at_mid && !maj) frm_acc <= 1'b1;
    end
  end

  // A completing frame only loads when the holding register is free or being drained.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!valid_out || ready_in) begin
          valid_out  <= 1'b1;
          data_out   <= shift_reg;
          parity_err <= par_err_r;
          frame_err  <= frm_acc | ~maj;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) driven with
// directed frames; a negedge monitor pops expected words on each valid&&ready.
module tb_uart_rx_cfg;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         exp_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_v    [3];
  logic       ready_v [3];
  logic       valid_v [3];
  logic [7:0] data_v  [3];
  logic       perr_v  [3];
  logic       ferr_v  [3];
  logic       ovr_v   [3];
  logic       busy_v  [3];

  int   npar  [3] = '{0, 1, 0};
  int   nstop [3] = '{1, 1, 2};
  int   ovr_cnt [3] = '{0, 0, 0};
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .rx(rx_v[0]), .ready_in(ready_v[0]), .valid_out(valid_v[0]),
    .data_out(data_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .rx(rx_v[1]), .ready_in(ready_v[1]), .valid_out(valid_v[1]),
    .data_out(data_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .rx(rx_v[2]), .ready_in(ready_v[2]), .valid_out(valid_v[2]),
    .data_out(data_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]));

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_word(input int i, input exp_t e);
    check_output($sformatf("inst%0d_data", i), {24'd0, data_v[i]}, {24'd0, e.data});
    check_output($sformatf("inst%0d_parity_err", i), {31'd0, perr_v[i]}, {31'd0, e.perr});
    check_output($sformatf("inst%0d_frame_err", i), {31'd0, ferr_v[i]}, {31'd0, e.ferr});
    if (e.exp_cyc >= 0) check_output($sformatf("inst%0d_valid_cycle", i), cyc, e.exp_cyc);
  endtask

  task automatic unexpected(input int i);
    checks++;
    failures++;
    $display("[TB] FAIL inst%0d_unexpected_word actual=0x%0h required=none", i, data_v[i]);
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (valid_v[0] && ready_v[0]) begin
        if (q0.size() == 0) unexpected(0); else check_word(0, q0.pop_front());
      end
      if (valid_v[1] && ready_v[1]) begin
        if (q1.size() == 0) unexpected(1); else check_word(1, q1.pop_front());
      end
      if (valid_v[2] && ready_v[2]) begin
        if (q2.size() == 0) unexpected(2); else check_word(2, q2.pop_front());
      end
      for (int i = 0; i < 3; i++) if (ovr_v[i]) ovr_cnt[i]++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One bit time; optional single-cycle flip lands on the cnt=M-1 sample.
  task automatic drive_bit(input int i, input logic v, input bit g);
    rx_v[i] = v;
    idle(8);
    if (g) rx_v[i] = ~v;
    idle(1);
    rx_v[i] = v;
    idle(7);
  endtask

  task automatic apply_stimulus(input int i, input logic [7:0] d, input logic par_bit,
                                input logic stop_val, input bit glitch);
    drive_bit(i, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(i, d[b], glitch);
    if (npar[i] != 0) drive_bit(i, par_bit, 1'b0);
    for (int s = 0; s < nstop[i]; s++) drive_bit(i, stop_val, 1'b0);
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic pe, input logic fe, input int ec);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.exp_cyc = ec;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("%s_valid%0d", tag, i), {31'd0, valid_v[i]}, 0);
      check_output($sformatf("%s_data%0d", tag, i), {24'd0, data_v[i]}, 0);
      check_output($sformatf("%s_perr%0d", tag, i), {31'd0, perr_v[i]}, 0);
      check_output($sformatf("%s_ferr%0d", tag, i), {31'd0, ferr_v[i]}, 0);
      check_output($sformatf("%s_ovr%0d", tag, i), {31'd0, ovr_v[i]}, 0);
      check_output($sformatf("%s_busy%0d", tag, i), {31'd0, busy_v[i]}, 0);
    end
  endtask

  initial begin
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin rx_v[i] = 1'b1; ready_v[i] = 1'b1; end
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_rst = 1'b1;
    idle(4);

    // 8N1 0xA5 with one flipped sample per data bit; valid 157 cycles after the pin falls.
    push(0, 8'hA5, 1'b0, 1'b0, cyc + 157);
    apply_stimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    idle(20);

    // Short low pulse is a false start.
    rx_v[0] = 1'b0;
    idle(4);
    rx_v[0] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_output("false_start_busy_at_m1", {31'd0, busy_v[0]}, 1);
    @(negedge clk);
    check_output("false_start_idle_at_m2", {31'd0, busy_v[0]}, 0);
    @(posedge clk); #1;
    idle(40);

    // Even parity: 0x37 needs parity 1.
    push(1, 8'h37, 1'b1, 1'b0, -1);
    apply_stimulus(1, 8'h37, 1'b0, 1'b1, 1'b0);
    idle(20);
    push(1, 8'h37, 1'b0, 1'b0, -1);
    apply_stimulus(1, 8'h37, 1'b1, 1'b1, 1'b0);
    idle(20);

    // Bad stop bit followed by a 40 bit-time break, then a clean word.
    push(0, 8'h3C, 1'b0, 1'b1, -1);
    apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(40 * 16);
    rx_v[0] = 1'b1;
    idle(32);
    push(0, 8'h55, 1'b0, 1'b0, -1);
    apply_stimulus(0, 8'h55, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Overrun: second word dropped while the first is held.
    ready_v[0] = 1'b0;
    push(0, 8'h11, 1'b0, 1'b0, -1);
    apply_stimulus(0, 8'h11, 1'b0, 1'b1, 1'b0);
    idle(20);
    apply_stimulus(0, 8'h22, 1'b0, 1'b1, 1'b0);
    idle(20);
    check_output("overrun_held_valid", {31'd0, valid_v[0]}, 1);
    check_output("overrun_held_data", {24'd0, data_v[0]}, 32'h11);
    check_output("overrun_pulse_count", ovr_cnt[0], 1);
    ready_v[0] = 1'b1;
    idle(10);
    check_output("overrun_popped_valid", {31'd0, valid_v[0]}, 0);

    // 8N2: hold a word, then reset during data bit 3 of the next frame.
    ready_v[2] = 1'b0;
    apply_stimulus(2, 8'h5A, 1'b0, 1'b1, 1'b0);
    idle(10);
    check_output("hold_before_reset_valid", {31'd0, valid_v[2]}, 1);
    d = 8'hC3;
    drive_bit(2, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) drive_bit(2, d[b], 1'b0);
    rx_v[2] = d[3];
    idle(8);
    check_output("busy_before_reset", {31'd0, busy_v[2]}, 1);
    n_rst = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    rx_v[2] = 1'b1;
    idle(2);
    n_rst = 1'b1;
    ready_v[2] = 1'b1;
    idle(20);
    push(2, 8'hC3, 1'b0, 1'b0, -1);
    apply_stimulus(2, 8'hC3, 1'b0, 1'b1, 1'b0);
    idle(30);

    check_output("q0_drained", q0.size(), 0);
    check_output("q1_drained", q1.size(), 0);
    check_output("q2_drained", q2.size(), 0);
    check_output("ovr_total_a", ovr_cnt[0], 1);
    check_output("ovr_total_b", ovr_cnt[1], 0);
    check_output("ovr_total_c", ovr_cnt[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
